// File: rtl/lw_sha_pkg.sv
// Shared types, constants and masked-word helpers for the SHA-2 message-schedule engine.
// Datapath helpers always work on 64-bit containers; mode 0 uses only the low 32 bits.
package lw_sha_pkg;

  localparam int WMAX   = 64;
  localparam int RW_MAX = $clog2(WMAX);

  localparam logic [6:0] ROUNDS_256 = 7'd64;
  localparam logic [6:0] ROUNDS_512 = 7'd80;

  localparam logic [5:0] S256_S0_R1 = 6'd7;
  localparam logic [5:0] S256_S0_R2 = 6'd18;
  localparam logic [5:0] S256_S0_SH = 6'd3;
  localparam logic [5:0] S256_S1_R1 = 6'd17;
  localparam logic [5:0] S256_S1_R2 = 6'd19;
  localparam logic [5:0] S256_S1_SH = 6'd10;
  localparam logic [5:0] S512_S0_R1 = 6'd1;
  localparam logic [5:0] S512_S0_R2 = 6'd8;
  localparam logic [5:0] S512_S0_SH = 6'd7;
  localparam logic [5:0] S512_S1_R1 = 6'd19;
  localparam logic [5:0] S512_S1_R2 = 6'd61;
  localparam logic [5:0] S512_S1_SH = 6'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic [RW_MAX-1:0] rot;
    logic [WMAX-1:0]   data;
  } mword_t;

  // Mode 0 rotates the low half only and forces the upper half to zero.
  function automatic logic [63:0] right_rotate(input logic [63:0] x, input logic [5:0] amt,
                                               input logic m64);
    logic [63:0] r;
    logic [31:0] lo;
    lo = (x[31:0] >> amt[4:0]) | (x[31:0] << (6'd32 - {1'b0, amt[4:0]}));
    if (m64) begin
      r = (x >> amt) | (x << (7'd64 - {1'b0, amt}));
    end else begin
      r = {32'd0, lo};
    end
    return r;
  endfunction

  function automatic mword_t write_word(input logic [63:0] data, input logic [5:0] rnd,
                                        input logic m64);
    mword_t mw;
    mw.rot  = m64 ? rnd : {1'b0, rnd[4:0]};
    mw.data = right_rotate(data, mw.rot, m64);
    return mw;
  endfunction

  // Right-rotating by (width - rot) undoes the mask; the 6-bit negate gives that modulo width.
  function automatic logic [63:0] read_word(input mword_t mw, input logic m64);
    return right_rotate(mw.data, 6'd0 - mw.rot, m64);
  endfunction

endpackage

// File: rtl/lw_sha_sigma.sv
// Combinational SHA-2 small sigma (sigma0 when SIGMA1=0, sigma1 otherwise) with runtime mode.
module lw_sha_sigma
  import lw_sha_pkg::*;
#(
  parameter bit SIGMA1 = 1'b0
) (
  input  logic [63:0] x_i,
  input  logic        mode_i,
  output logic [63:0] y_o
);

  logic [5:0]  ra;
  logic [5:0]  rb;
  logic [5:0]  sh;
  logic [63:0] xs;

  // Select rotate/shift amounts for the active mode and evaluate the sigma
  always_comb begin
    ra = 6'd0;
    rb = 6'd0;
    sh = 6'd0;
    if (SIGMA1) begin
      if (mode_i) begin
        ra = S512_S1_R1; rb = S512_S1_R2; sh = S512_S1_SH;
      end else begin
        ra = S256_S1_R1; rb = S256_S1_R2; sh = S256_S1_SH;
      end
    end else begin
      if (mode_i) begin
        ra = S512_S0_R1; rb = S512_S0_R2; sh = S512_S0_SH;
      end else begin
        ra = S256_S0_R1; rb = S256_S0_R2; sh = S256_S0_SH;
      end
    end
    xs  = mode_i ? x_i : {32'd0, x_i[31:0]};
    y_o = right_rotate(xs, ra, mode_i) ^ right_rotate(xs, rb, mode_i) ^ (xs >> sh);
  end

endmodule

// File: rtl/lw_sha_msg_sched.sv
// Masked SHA-256/512 message schedule: loads 16 words, streams W[0..R-1] over valid/ready.
// Define LW_SHA_SCHED_MASK_EN to enable rotation masking driven by rnd_i.
module lw_sha_msg_sched
  import lw_sha_pkg::*;
#(
  parameter int WORD_SIZE = 64,
  parameter int RW        = $clog2(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [WORD_SIZE-1:0] msg_i,
  input  logic                 msg_valid_i,
  output logic                 msg_ready_o,
  input  logic [RW-1:0]        rnd_i,
  output logic [WORD_SIZE-1:0] w_o,
  output logic [RW-1:0]        w_rot_o,
  output logic [6:0]           w_idx_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic IS64 = (WORD_SIZE == 64);

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  t_q, t_d;
  logic [6:0]  w_idx_q, w_idx_d;
  logic        w_valid_q, w_valid_d;
  logic        msg_ready_q, msg_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  mword_t      w_q, w_d;
  mword_t      wbuf_q [16];
  mword_t      wbuf_d [16];

  logic [5:0]  rnd_ext;
  logic [63:0] msg_ext;
  logic [3:0]  p;
  logic [63:0] op0, op1, op9, op14, sig0, sig1, sum;
  logic [6:0]  rounds;
  mword_t      nxt;

`ifdef LW_SHA_SCHED_MASK_EN
  assign rnd_ext = 6'(rnd_i);
`else
  logic rnd_unused;
  assign rnd_unused = ^rnd_i;
  assign rnd_ext    = 6'd0;
`endif

  assign msg_ext = 64'(msg_i);
  assign rounds  = mode_q ? ROUNDS_512 : ROUNDS_256;

  // The window p, p+1, p+9, p+14 of the circular buffer holds W[t-16], W[t-15], W[t-7], W[t-2].
  assign p    = t_q[3:0];
  assign op0  = read_word(wbuf_q[p], mode_q);
  assign op1  = read_word(wbuf_q[p + 4'd1], mode_q);
  assign op9  = read_word(wbuf_q[p + 4'd9], mode_q);
  assign op14 = read_word(wbuf_q[p + 4'd14], mode_q);
  assign sum  = sig1 + op9 + sig0 + op0;

  lw_sha_sigma #(.SIGMA1(1'b0)) u_sigma0 (.x_i(op1),  .mode_i(mode_q), .y_o(sig0));
  lw_sha_sigma #(.SIGMA1(1'b1)) u_sigma1 (.x_i(op14), .mode_i(mode_q), .y_o(sig1));

  // Freshly masked schedule word for index t_q; below 16 it is a re-masked copy of the buffer
  always_comb begin
    if (t_q < 7'd16) begin
      nxt = write_word(op0, rnd_ext, mode_q);
    end else begin
      nxt = write_word(sum, rnd_ext, mode_q);
    end
  end

  // Next-state logic for the FSM, buffer and output register
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    t_d       = t_q;
    w_d       = w_q;
    w_idx_d   = w_idx_q;
    w_valid_d = w_valid_q;
    wbuf_d    = wbuf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
          mode_d  = mode_i & IS64;
          cnt_d   = 4'd0;
          t_d     = 7'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (msg_valid_i) begin
          wbuf_d[cnt_q] = write_word(msg_ext, rnd_ext, mode_q);
          cnt_d         = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            // W[0] already sits in the buffer, so the stream can start on this edge
            state_d   = ST_EXPAND;
            w_d       = nxt;
            w_idx_d   = t_q;
            w_valid_d = 1'b1;
            t_d       = t_q + 7'd1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_EXPAND: begin
        if (w_valid_q && w_ready_i && (w_idx_q == rounds - 7'd1)) begin
          state_d   = ST_DONE;
          w_valid_d = 1'b0;
        end else if ((!w_valid_q || w_ready_i) && (t_q < rounds)) begin
          w_d       = nxt;
          w_idx_d   = t_q;
          w_valid_d = 1'b1;
          t_d       = t_q + 7'd1;
          if (t_q >= 7'd16) begin
            wbuf_d[p] = nxt;
          end else begin
            wbuf_d[p] = wbuf_q[p];
          end
        end else begin
          w_valid_d = w_valid_q & ~w_ready_i;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    msg_ready_d = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // State, buffer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      cnt_q       <= 4'd0;
      t_q         <= 7'd0;
      w_q         <= '0;
      w_idx_q     <= 7'd0;
      w_valid_q   <= 1'b0;
      msg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        wbuf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      t_q         <= t_d;
      w_q         <= w_d;
      w_idx_q     <= w_idx_d;
      w_valid_q   <= w_valid_d;
      msg_ready_q <= msg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wbuf_q      <= wbuf_d;
    end
  end

  assign w_o         = w_q.data[WORD_SIZE-1:0];
  assign w_rot_o     = w_q.rot[RW-1:0];
  assign w_idx_o     = w_idx_q;
  assign w_valid_o   = w_valid_q;
  assign msg_ready_o = msg_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_lw_sha_msg_sched.sv
// Self-checking bench for lw_sha_msg_sched against a plain-array SHA-2 schedule model.
module tb_lw_sha_msg_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [63:0] msg_i = 64'd0;
  logic        msg_valid_i = 1'b0;
  logic        msg_ready_o;
  logic [5:0]  rnd_i = 6'd0;
  logic [63:0] w_o;
  logic [5:0]  w_rot_o;
  logic [6:0]  w_idx_o;
  logic        w_valid_o;
  logic        w_ready_i = 1'b0;
  logic        busy_o;
  logic        done_o;

`ifdef LW_SHA_SCHED_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [63:0] blk_msg [16];
  logic [63:0] cap [80];

  typedef struct {
    bit         mode;
    bit         abc;
    int         ready_pct;
    bit         rnd_rand;
    logic [5:0] rnd_fix;
    bit         disturb;
  } cfg_t;

  typedef struct {
    bit          mode;
    int          t;
    logic [63:0] exp;
  } spot_t;

  cfg_t  cfgs [7];
  spot_t spots [5];

  lw_sha_msg_sched #(.WORD_SIZE(64)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .msg_i(msg_i),
    .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .rnd_i(rnd_i), .w_o(w_o),
    .w_rot_o(w_rot_o), .w_idx_o(w_idx_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_rotr(input logic [63:0] x, input int n, input bit m64);
    logic [31:0] v;
    if (m64) return (x >> n) | (x << (64 - n));
    v = x[31:0];
    v = (v >> n) | (v << (32 - n));
    return {32'd0, v};
  endfunction

  // Textbook SHA-2 schedule over a flat array.
  function automatic void build_sched(input bit m64, output logic [63:0] w [80]);
    logic [63:0] s0, s1, x15, x2;
    for (int t = 0; t < 80; t++) w[t] = 64'd0;
    for (int t = 0; t < 16; t++) w[t] = m64 ? blk_msg[t] : {32'd0, blk_msg[t][31:0]};
    for (int t = 16; t < (m64 ? 80 : 64); t++) begin
      x15 = w[t-15];
      x2  = w[t-2];
      if (m64) begin
        s0 = ref_rotr(x15, 1, 1) ^ ref_rotr(x15, 8, 1) ^ (x15 >> 7);
        s1 = ref_rotr(x2, 19, 1) ^ ref_rotr(x2, 61, 1) ^ (x2 >> 6);
      end else begin
        s0 = ref_rotr(x15, 7, 0) ^ ref_rotr(x15, 18, 0) ^ (x15 >> 3);
        s1 = ref_rotr(x2, 17, 0) ^ ref_rotr(x2, 19, 0) ^ (x2 >> 10);
      end
      w[t] = s1 + w[t-7] + s0 + w[t-16];
      if (!m64) w[t][63:32] = 32'd0;
    end
  endfunction

  task automatic run_block(input bit m64, input int ready_pct, input bit rnd_rand,
                           input logic [5:0] rnd_fix, input bit disturb, input int abort_at);
    logic [63:0] wexp [80];
    logic [63:0] pw;
    logic [5:0]  prot, exp_rot;
    logic [6:0]  pidx;
    int rounds, width, n, cyc;
    bit prev_stall, early_done;
    build_sched(m64, wexp);
    rounds  = m64 ? 80 : 64;
    width   = m64 ? 64 : 32;
    exp_rot = MASK_EN ? (m64 ? rnd_fix : {1'b0, rnd_fix[4:0]}) : 6'd0;
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = m64;
    @(negedge clk);
    start_i = 1'b0;
    chk("load_ready", {63'd0, msg_ready_o & busy_o}, 64'd1);
    for (int i = 0; i < 16; i++) begin
      msg_valid_i = 1'b1;
      msg_i       = blk_msg[i];
      rnd_i       = rnd_rand ? 6'($urandom) : rnd_fix;
      if (disturb && i == 5) start_i = 1'b1;
      if (disturb) mode_i = 1'($urandom);
      @(negedge clk);
      start_i = 1'b0;
    end
    msg_valid_i = 1'b0;
    chk("first_valid", {62'd0, w_valid_o, msg_ready_o}, 64'd2);
    n = 0; cyc = 0; prev_stall = 1'b0; early_done = 1'b0;
    pw = 64'd0; prot = 6'd0; pidx = 7'd0;
    while (n < rounds && n != abort_at && cyc < 3000) begin
      if (prev_stall) chk("stall_hold", {w_o ^ pw, 1'b0, w_rot_o, w_idx_o}, {64'd0, 1'b0, prot, pidx});
      if (disturb) begin
        msg_valid_i = 1'($urandom);
        msg_i       = {$urandom, $urandom};
      end
      rnd_i     = rnd_rand ? 6'($urandom) : rnd_fix;
      w_ready_i = ($urandom_range(99) < ready_pct);
      if (done_o) early_done = 1'b1;
      if (w_valid_o && w_ready_i) begin
        chk("w_idx", 64'(w_idx_o), 64'(n));
        chk("w_masked", w_o, ref_rotr(wexp[n], int'(w_rot_o), m64));
        if (!rnd_rand || !MASK_EN) chk("w_rot", 64'(w_rot_o), 64'(exp_rot));
        else if (!m64) chk("w_rot_range", 64'(w_rot_o[5]), 64'd0);
        cap[n] = ref_rotr(w_o, (width - int'(w_rot_o)) % width, m64);
        n++;
      end
      prev_stall = w_valid_o && !w_ready_i;
      pw = w_o; prot = w_rot_o; pidx = w_idx_o;
      @(negedge clk);
      cyc++;
    end
    msg_valid_i = 1'b0;
    if (abort_at >= 0) return;
    chk("word_count", 64'(n), 64'(rounds));
    chk("no_early_done", 64'(early_done), 64'd0);
    w_ready_i = 1'b0;
    chk("done_pulse", {62'd0, done_o, w_valid_o}, 64'd2);
    @(negedge clk);
    chk("back_idle", {62'd0, done_o, busy_o}, 64'd0);
  endtask

  task automatic load_msg(input bit m64, input bit abc);
    for (int i = 0; i < 16; i++) blk_msg[i] = {$urandom, $urandom};
    if (abc) begin
      for (int i = 0; i < 16; i++) blk_msg[i] = 64'd0;
      blk_msg[0]  = m64 ? 64'h6162638000000000 : 64'h0000000061626380;
      blk_msg[15] = 64'h18;
    end
  endtask

  initial begin
    cfgs[0] = '{1'b0, 1'b1, 100, 1'b0, 6'd0,  1'b0};
    cfgs[1] = '{1'b0, 1'b1, 100, 1'b1, 6'd0,  1'b0};
    cfgs[2] = '{1'b1, 1'b1, 100, 1'b0, 6'd45, 1'b0};
    cfgs[3] = '{1'b0, 1'b1, 50,  1'b0, 6'd45, 1'b0};
    cfgs[4] = '{1'b0, 1'b0, 50,  1'b1, 6'd0,  1'b1};
    cfgs[5] = '{1'b1, 1'b0, 50,  1'b1, 6'd0,  1'b1};
    cfgs[6] = '{1'b1, 1'b1, 50,  1'b1, 6'd0,  1'b0};
    spots[0] = '{1'b0, 0,  64'h0000000061626380};
    spots[1] = '{1'b0, 16, 64'h0000000061626380};
    spots[2] = '{1'b0, 17, 64'h00000000000F0000};
    spots[3] = '{1'b1, 16, 64'h6162638000000000};
    spots[4] = '{1'b1, 17, 64'h00030000000000C0};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {w_o, 1'b0, w_rot_o, w_idx_o, w_valid_o, busy_o, done_o, msg_ready_o},
        {64'd0, 1'b0, 6'd0, 7'd0, 4'd0});
    rst = 1'b0;

    for (int c = 0; c < 7; c++) begin
      load_msg(cfgs[c].mode, cfgs[c].abc);
      run_block(cfgs[c].mode, cfgs[c].ready_pct, cfgs[c].rnd_rand, cfgs[c].rnd_fix,
                cfgs[c].disturb, -1);
      if (cfgs[c].abc) begin
        for (int s = 0; s < 5; s++) begin
          if (spots[s].mode == cfgs[c].mode) chk($sformatf("abc_w%0d", spots[s].t),
                                                 cap[spots[s].t], spots[s].exp);
        end
      end
    end

    // Reset in the middle of expansion, then a fresh block must stream correctly.
    load_msg(1'b1, 1'b0);
    run_block(1'b1, 70, 1'b1, 6'd0, 1'b0, 30);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {w_o, 1'b0, w_rot_o, w_idx_o, w_valid_o, busy_o, done_o, msg_ready_o},
        {64'd0, 1'b0, 6'd0, 7'd0, 4'd0});
    @(negedge clk);
    rst = 1'b0;
    load_msg(1'b0, 1'b1);
    run_block(1'b0, 100, 1'b1, 6'd0, 1'b0, -1);
    chk("post_rst_w16", cap[16], 64'h0000000061626380);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
